// File: rtl/char_rom_arbiter.sv
// Round-robin arbiter sharing one char glyph ROM among several line builders.
// Grant indices travel through a tag pipeline to route each ROM row back to its owner.
module char_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ROM_LATENCY = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      line_start,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAST  = ROM_LATENCY - 1;

  logic [NUM_REQ-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0]       gnt_idx_q, gnt_idx_d;
  logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [ROM_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]       tag_idx_q [ROM_LATENCY];
  logic [IDX_W-1:0]       tag_idx_d [ROM_LATENCY];
  logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]      rsp_data_q, rsp_data_d;

  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic [IDX_W:0]         cand;

  // Rotating search starting at ptr; one spare bit on cand absorbs the wrap.
  always_comb begin : arb_search
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!win_found && req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin : arb_next
    gnt_d      = '0;
    gnt_idx_d  = gnt_idx_q;
    rom_addr_d = rom_addr_q;
    ptr_d      = ptr_q;
    if (line_start) begin
      ptr_d = '0;
    end else if (win_found) begin
      gnt_d[win_idx] = 1'b1;
      gnt_idx_d      = win_idx;
      rom_addr_d     = req_addr[win_idx*ADDR_W +: ADDR_W];
      ptr_d          = (win_idx == IDX_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Tags are loaded from the registered grant so the last stage lines up with rom_q.
  always_comb begin : tag_next
    tag_vld_d    = '0;
    tag_idx_d[0] = gnt_idx_q;
    for (int s = 1; s < ROM_LATENCY; s++) begin
      tag_idx_d[s] = tag_idx_q[s-1];
    end
    if (!line_start) begin
      tag_vld_d[0] = |gnt_q;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        tag_vld_d[s] = tag_vld_q[s-1];
      end
    end
  end

  always_comb begin : rsp_next
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (!line_start && tag_vld_q[LAST]) begin
      rsp_valid_d[tag_idx_q[LAST]] = 1'b1;
      rsp_data_d                   = rom_q;
    end
  end

  always_ff @(posedge clock) begin : state_reg
    if (!reset_n) begin
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      rom_addr_q  <= '0;
      ptr_q       <= '0;
      tag_vld_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int s = 0; s < ROM_LATENCY; s++) begin
        tag_idx_q[s] <= '0;
      end
    end else begin
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      rom_addr_q  <= rom_addr_d;
      ptr_q       <= ptr_d;
      tag_vld_q   <= tag_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int s = 0; s < ROM_LATENCY; s++) begin
        tag_idx_q[s] <= tag_idx_d[s];
      end
    end
  end

  always_comb begin : outputs
    gnt       = gnt_q;
    rom_addr  = rom_addr_q;
    rsp_valid = rsp_valid_q;
    rsp_data  = rsp_data_q;
    busy      = (|tag_vld_q) | (|gnt_q);
  end

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Directed bench for char_rom_arbiter: ROM latency 2 instance for arbitration,
// plus latency 1 and 4 instances sharing the stimulus for the burst timing check.
module tb_char_rom_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        line_start;
  logic [3:0]  req;
  logic [7:0]  slot_addr [4];
  logic [31:0] req_addr;

  logic [3:0] gnt1, gnt2, gnt4, rv1, rv2, rv4;
  logic [7:0] ra1, ra2, ra4, rq1, rq2, rq4, rd1, rd2, rd4;
  logic       busy1, busy2, busy4;

  logic [7:0] pipe1 [1];
  logic [7:0] pipe2 [2];
  logic [7:0] pipe4 [4];

  int checks   = 0;
  int failures = 0;

  logic [3:0] q_req [$];
  bit         q_ls  [$];
  bit         q_rst [$];
  int         e_g   [$];
  int         e_r   [$];
  int         e_b   [$];

  logic [3:0] lv [3][25];
  logic [7:0] ld [3][25];

  always #5 clock = ~clock;

  assign req_addr = {slot_addr[3], slot_addr[2], slot_addr[1], slot_addr[0]};

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    return {a[3:0], a[7:4]} ^ 8'h5A;
  endfunction

  function automatic logic [3:0] oh(input int i);
    if (i < 0) return 4'b0000;
    return 4'b0001 << i;
  endfunction

  always @(posedge clock) begin
    pipe1[0] <= rom_fn(ra1);
    pipe2[0] <= rom_fn(ra2);
    pipe2[1] <= pipe2[0];
    pipe4[0] <= rom_fn(ra4);
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end

  assign rq1 = pipe1[0];
  assign rq2 = pipe2[1];
  assign rq4 = pipe4[3];

  char_rom_arbiter #(.NUM_REQ(4), .ROM_LATENCY(2), .ADDR_W(8), .DATA_W(8)) u_lat2 (
    .clock(clock), .reset_n(reset_n), .line_start(line_start), .req(req), .req_addr(req_addr),
    .gnt(gnt2), .rom_addr(ra2), .rom_q(rq2), .rsp_valid(rv2), .rsp_data(rd2), .busy(busy2));

  char_rom_arbiter #(.NUM_REQ(4), .ROM_LATENCY(1), .ADDR_W(8), .DATA_W(8)) u_lat1 (
    .clock(clock), .reset_n(reset_n), .line_start(line_start), .req(req), .req_addr(req_addr),
    .gnt(gnt1), .rom_addr(ra1), .rom_q(rq1), .rsp_valid(rv1), .rsp_data(rd1), .busy(busy1));

  char_rom_arbiter #(.NUM_REQ(4), .ROM_LATENCY(4), .ADDR_W(8), .DATA_W(8)) u_lat4 (
    .clock(clock), .reset_n(reset_n), .line_start(line_start), .req(req), .req_addr(req_addr),
    .gnt(gnt4), .rom_addr(ra4), .rom_q(rq4), .rsp_valid(rv4), .rsp_data(rd4), .busy(busy4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One entry per clock edge: inputs for that edge, then outputs expected just after it.
  task automatic run_seq(input string name);
    for (int k = 0; k < e_g.size(); k++) begin
      req        = q_req[k];
      line_start = q_ls[k];
      reset_n    = q_rst[k];
      @(posedge clock);
      #1;
      chk($sformatf("%s.gnt[%0d]", name, k), 32'(gnt2), 32'(oh(e_g[k])));
      if (e_g[k] >= 0)
        chk($sformatf("%s.rom_addr[%0d]", name, k), 32'(ra2), 32'(slot_addr[e_g[k]]));
      chk($sformatf("%s.rsp_valid[%0d]", name, k), 32'(rv2), 32'(oh(e_r[k])));
      if (e_r[k] >= 0)
        chk($sformatf("%s.rsp_data[%0d]", name, k), 32'(rd2), 32'(rom_fn(slot_addr[e_r[k]])));
      if (k < e_b.size() && e_b[k] != 2)
        chk($sformatf("%s.busy[%0d]", name, k), 32'(busy2), 32'(e_b[k]));
      if (!q_rst[k]) begin
        chk($sformatf("%s.rst_rom_addr[%0d]", name, k), 32'(ra2), 32'h0);
        chk($sformatf("%s.rst_rsp_data[%0d]", name, k), 32'(rd2), 32'h0);
      end
    end
    req        = '0;
    line_start = 1'b0;
    reset_n    = 1'b1;
  endtask

  initial begin
    int lat [3];
    int cnt;
    int j;
    lat = '{1, 2, 4};

    reset_n    = 1'b0;
    line_start = 1'b0;
    req        = '0;
    slot_addr  = '{8'h10, 8'h20, 8'h30, 8'h40};
    repeat (2) @(posedge clock);
    #1;
    chk("reset.gnt", 32'(gnt2), 32'h0);
    chk("reset.rom_addr", 32'(ra2), 32'h0);
    chk("reset.rsp_valid", 32'(rv2), 32'h0);
    chk("reset.rsp_data", 32'(rd2), 32'h0);
    chk("reset.busy", 32'(busy2), 32'h0);
    reset_n = 1'b1;

    // single requester 1, address 0x35
    slot_addr[1] = 8'h35;
    q_req = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    q_ls  = '{0, 0, 0, 0, 0};
    q_rst = '{1, 1, 1, 1, 1};
    e_g   = '{1, -1, -1, -1, -1};
    e_r   = '{-1, -1, -1, 1, -1};
    e_b   = '{1, 1, 1, 2, 0};
    run_seq("single");
    slot_addr[1] = 8'h20;

    // ptr is 2 here; req=1011 gives 3,0,1,3,0,1
    q_req = '{4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b0000, 4'b0000, 4'b0000};
    q_ls  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    q_rst = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    e_g   = '{3, 0, 1, 3, 0, 1, -1, -1, -1};
    e_r   = '{-1, -1, -1, 3, 0, 1, 3, 0, 1};
    e_b   = '{1};
    run_seq("ptr2");

    // two grants (2,3), line_start drops them, then full rotation from 0
    q_req = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
    q_ls  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    q_rst = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    e_g   = '{2, 3, -1, 0, 1, 2, 3, 0, 1, 2, 3, -1, -1, -1};
    e_r   = '{-1, -1, -1, -1, -1, -1, 0, 1, 2, 3, 0, 1, 2, 3};
    e_b   = '{1, 1, 0};
    run_seq("linestart");

    // reset mid-burst, arbitration restarts from index 0
    q_req = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    q_ls  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    q_rst = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1, 1};
    e_g   = '{0, 1, 2, -1, 0, 1, -1, -1, -1, -1, -1, -1};
    e_r   = '{-1, -1, -1, -1, -1, -1, -1, 0, 1, -1, -1, -1};
    e_b   = '{1, 1, 1, 0};
    run_seq("midreset");

    repeat (4) @(posedge clock);
    #1;

    // back-to-back reads by requester 0, addresses 0x00..0x0F
    slot_addr[0] = 8'h00;
    req          = 4'b0001;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clock);
      #1;
      if (k <= 16) begin
        chk($sformatf("burst.gnt[%0d]", k), 32'(gnt2), 32'h1);
        chk($sformatf("burst.rom_addr[%0d]", k), 32'(ra2), 32'(k - 1));
      end
      lv[0][k] = rv1; ld[0][k] = rd1;
      lv[1][k] = rv2; ld[1][k] = rd2;
      lv[2][k] = rv4; ld[2][k] = rd4;
      if (k < 16) slot_addr[0] = 8'(k);
      else        req = '0;
    end

    for (int n = 0; n < 3; n++) begin
      cnt = 0;
      for (int k = 1; k <= 24; k++) begin
        j = k - 2 - lat[n];
        if (lv[n][k] != 4'b0000) cnt++;
        if (j >= 0 && j < 16) begin
          chk($sformatf("burst_l%0d.rsp_valid[%0d]", lat[n], k), 32'(lv[n][k]), 32'h1);
          chk($sformatf("burst_l%0d.rsp_data[%0d]", lat[n], k), 32'(ld[n][k]), 32'(rom_fn(8'(j))));
        end else begin
          chk($sformatf("burst_l%0d.rsp_valid[%0d]", lat[n], k), 32'(lv[n][k]), 32'h0);
        end
      end
      chk($sformatf("burst_l%0d.strobes", lat[n]), 32'(cnt), 32'd16);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/char_rom_arbiter.md
Name: char_rom_arbiter

Overview:
- Shares the single-port character glyph ROM (8-bit address, 8-bit glyph row) among several line builders: lag digits, min/max/avg digits, resolution text and future overlays.
- Grants one ROM read per clock using round-robin arbitration.
- Tracks each in-flight read through the ROM pipeline and returns the glyph row to the requester that owns it.
- Sits between the text generation state machines and the char ROM instance. The ROM is re-timed per video line via `line_start`.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ROM_LATENCY, 2, clocks from `rom_addr` register update to valid `rom_q`; legal range 1..4.
- ADDR_W, 8, char ROM address width.
- DATA_W, 8, glyph row width.

Ports:
- clock  in  1  system pixel clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- line_start  in  1  one-cycle pulse at start of each video line (counterX==0).
- req  in  NUM_REQ  per-requester read request; level, held until granted.
- req_addr  in  NUM_REQ*ADDR_W  per-requester address; slice i = [i*ADDR_W +: ADDR_W]; stable while req[i] is high.
- gnt  out  NUM_REQ  one-hot grant pulse; registered.
- rom_addr  out  ADDR_W  address driven to char ROM; registered.
- rom_q  in  DATA_W  char ROM read data.
- rsp_valid  out  NUM_REQ  one-hot response strobe; registered.
- rsp_data  out  DATA_W  glyph row, valid when any rsp_valid bit is set.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (reset_n==0 at a clock edge): the following clear to 0.
  - gnt, rom_addr, rsp_valid, rsp_data, busy.
  - Round-robin pointer `ptr`.
  - All in-flight tag stages.
- Arbitration, each cycle:
  - Search req starting at index `ptr`, wrapping modulo NUM_REQ. The first set bit k wins.
  - Next edge: gnt <= one-hot(k), rom_addr <= req_addr[k], ptr <= (k+1) mod NUM_REQ.
  - No req set: gnt <= 0, rom_addr holds its value, ptr unchanged.
- Handshake:
  - A request is consumed on the cycle gnt[i] is high.
  - A requester holding req[i] high through gnt issues a new request, with req_addr sampled in that cycle. Back-to-back reads are therefore allowed.
  - Under contention a requester waits at most NUM_REQ-1 cycles for a grant.
  - The arbiter samples req combinationally against registered gnt. The requester must drop req[i] or change req_addr in the cycle gnt[i] is seen, or it gets a duplicate grant when it is the only requester.
- Tag pipeline:
  - Each grant pushes {valid=1, idx=k} into a ROM_LATENCY-deep shift register; a cycle with no grant pushes valid=0.
  - When the stage aligned with rom_q is valid: rsp_valid <= one-hot(idx) and rsp_data <= rom_q.
  - Otherwise rsp_valid <= 0 and rsp_data holds.
  - Total latency: req sampled at edge N gives gnt high after N, and rsp_valid high after edge N+1+ROM_LATENCY.
- busy = OR of all tag-stage valid bits plus (gnt != 0).
- line_start:
  - At the edge where it is sampled high, all tag-stage valid bits clear, so in-flight responses are dropped and never strobe rsp_valid.
  - ptr <= 0 and gnt <= 0; no grant is issued that cycle even if req is set.
  - Arbitration resumes the next cycle.
  - If reset_n and line_start are both active, reset wins (same result).
- Responses return strictly in grant order. Exactly one rsp_valid strobe per accepted grant, unless dropped by line_start or reset.
- gnt and rsp_valid are each one-hot or zero in every cycle.

Test Plan:
- Single requester, ROM model latency 2: req[1]=1 with addr 0x35 for one grant → gnt=0010 one cycle; rom_addr=0x35; rsp_valid=0010 exactly 3 cycles after req sampled; rsp_data = ROM[0x35].
- All four requesters held high, addrs 0x10/0x20/0x30/0x40, ptr=0 → grants 0,1,2,3,0,1… one per cycle; responses return in the same order with matching data; no gaps.
- ptr=2 with req=1011 → grant order 3,0,1,3,…; req[2]=0 never granted.
- line_start pulse one cycle after two grants issued → neither response strobes; ptr=0; next grant the following cycle goes to lowest set req index.
- reset_n=0 mid-burst for one cycle → all outputs 0 on next edge; no stale rsp_valid afterwards; arbitration restarts from index 0.
- ROM_LATENCY=1 and =4 builds: back-to-back grants to requester 0 with addrs 0x00..0x0F → 16 rsp_valid strobes, latency 1+ROM_LATENCY, data matching ROM in order.
